// File: rtl/bit_deser_pkg.sv
// Shared types and constants for the bit_deser serial capture stage.
package bit_deser_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      DATA = 2'b01,
      PAR  = 2'b10
   } state_e;

   localparam logic        PARITY_EVEN = 1'b0;
   localparam int unsigned WIDTH_MIN   = 2;
   localparam int unsigned WIDTH_MAX   = 32;

endpackage

// File: rtl/deser_fsm.sv
// Frame sequencer: tracks the data-bit position and flags bit capture,
// frame restart on sof, and parity-bit completion.
module deser_fsm
   import bit_deser_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       clr_n,
   input  logic                       bit_en,
   input  logic                       sof,
   output logic                       shift_en,
   output logic                       frame_start,
   output logic [$clog2(WIDTH)-1:0]   bit_idx,
   output logic                       frame_done
);

   localparam int unsigned     CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shift_en    = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      bit_idx     = cnt_q;
      // sof restarts the frame from any state, silently dropping partial data
      if (bit_en && sof) begin
         shift_en    = 1'b1;
         frame_start = 1'b1;
         bit_idx     = '0;
         cnt_d       = CW'(1);
         state_d     = DATA;
      end else if (bit_en) begin
         unique case (state_q)
            IDLE: ;
            DATA: begin
               shift_en = 1'b1;
               if (cnt_q == LAST) begin
                  cnt_d   = '0;
                  state_d = PAR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
            PAR: begin
               frame_done = 1'b1;
               state_d    = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: rtl/bit_deser.sv
// Serial-to-parallel capture with even-parity check, single output buffer
// behind a valid/ready handshake, and sticky parity/overrun flags.
module bit_deser
   import bit_deser_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             clr_n,
   input  logic             bit_in,
   input  logic             bit_en,
   input  logic             sof,
   input  logic             err_clr,
   output logic [WIDTH-1:0] word_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             parity_err,
   output logic             overrun
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic             shift_en, frame_start, frame_done;
   logic [CW-1:0]    bit_idx;

   logic [WIDTH-1:0] shift_q, shift_d;
   logic             par_q, par_d;
   logic [WIDTH-1:0] word_q, word_d;
   logic             valid_q, valid_d;
   logic             perr_q, perr_d;
   logic             ovr_q, ovr_d;
   logic             frame_bad, buf_free;

   deser_fsm #(.WIDTH(WIDTH)) u_fsm (
      .clk         (clk),
      .clr_n       (clr_n),
      .bit_en      (bit_en),
      .sof         (sof),
      .shift_en    (shift_en),
      .frame_start (frame_start),
      .bit_idx     (bit_idx),
      .frame_done  (frame_done)
   );

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         shift_q <= '0;
         par_q   <= 1'b0;
         word_q  <= '0;
         valid_q <= 1'b0;
         perr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         shift_q <= shift_d;
         par_q   <= par_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         perr_q  <= perr_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      shift_d = shift_q;
      par_d   = par_q;
      word_d  = word_q;
      valid_d = valid_q;
      if (shift_en) begin
         if (frame_start) begin
            shift_d    = '0;
            shift_d[0] = bit_in;
            par_d      = bit_in;
         end else begin
            shift_d[bit_idx] = bit_in;
            par_d            = par_q ^ bit_in;
         end
      end
      frame_bad = frame_done && ((par_q ^ bit_in) != PARITY_EVEN);
      // a word accepted on this edge frees the buffer for the completing frame
      buf_free  = !valid_q || word_ready;
      if (frame_done && buf_free) begin
         word_d  = shift_q;
         valid_d = 1'b1;
      end else if (valid_q && word_ready) begin
         valid_d = 1'b0;
      end
      perr_d = (perr_q && !err_clr) || frame_bad;
      ovr_d  = (ovr_q && !err_clr) || (frame_done && !buf_free);
   end

   assign word_out   = word_q;
   assign word_valid = valid_q;
   assign parity_err = perr_q;
   assign overrun    = ovr_q;

endmodule

// File: tb/tb_bit_deser.sv
// Self-checking bench for bit_deser: directed table, corner sequences and
// random traffic against a frame-level reference model.
module tb_bit_deser;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         clr_n = 1'b1;
   logic         bit_in = 1'b0, bit_en = 1'b0, sof = 1'b0, err_clr = 1'b0, word_ready = 1'b0;
   logic [W-1:0] word_out;
   logic         word_valid, parity_err, overrun;

   int unsigned n_chk = 0, n_fail = 0, words_seen = 0;

   always #5 clk = ~clk;

   bit_deser #(.WIDTH(W)) dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .bit_in     (bit_in),
      .bit_en     (bit_en),
      .sof        (sof),
      .err_clr    (err_clr),
      .word_out   (word_out),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .parity_err (parity_err),
      .overrun    (overrun)
   );

   // reference model: bits collected since the last sof, plus output buffer
   bit           q_bits[$];
   logic [W-1:0] m_word;
   logic         m_valid, m_perr, m_ovr;

   typedef struct {
      logic         en, s, b, rdy, ec;
      logic         ev;
      logic [W-1:0] ew;
      logic         ep, eo;
   } vec_t;
   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q_bits.delete();
      m_word  = '0;
      m_valid = 1'b0;
      m_perr  = 1'b0;
      m_ovr   = 1'b0;
   endtask

   task automatic model_step();
      logic         done, bad, free;
      logic [W-1:0] w;
      done = 1'b0;
      bad  = 1'b0;
      w    = '0;
      if (bit_en) begin
         if (sof) begin
            q_bits.delete();
            q_bits.push_back(bit_in);
         end else if (q_bits.size() > 0) begin
            q_bits.push_back(bit_in);
            if (q_bits.size() == W + 1) begin
               done = 1'b1;
               for (int i = 0; i < int'(W); i++) w[i] = q_bits[i];
               foreach (q_bits[i]) bad = bad ^ q_bits[i];
               q_bits.delete();
            end
         end
      end
      free   = !m_valid || word_ready;
      m_perr = (m_perr && !err_clr) || (done && bad);
      m_ovr  = (m_ovr && !err_clr) || (done && !free);
      if (done && free) begin
         m_word  = w;
         m_valid = 1'b1;
      end else if (m_valid && word_ready) begin
         m_valid = 1'b0;
      end
   endtask

   task automatic cyc(input logic en, input logic s, input logic b, input logic rdy, input logic ec);
      bit_en     = en;
      sof        = s;
      bit_in     = b;
      word_ready = rdy;
      err_clr    = ec;
      @(posedge clk);
      model_step();
      #1;
      if (word_valid === 1'b1) words_seen++;
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 32'(word_valid), 32'(m_valid));
      chk({tag, ".word"},  32'(word_out),   32'(m_word));
      chk({tag, ".perr"},  32'(parity_err), 32'(m_perr));
      chk({tag, ".ovr"},   32'(overrun),    32'(m_ovr));
   endtask

   task automatic send_frame(input logic [W-1:0] d, input logic flip, input logic rdy,
                             input logic rdy_last, input logic ec_last, input string tag);
      for (int i = 0; i < int'(W); i++) begin
         cyc(1'b1, i == 0, d[i], rdy, 1'b0);
         check_model(tag);
      end
      cyc(1'b1, 1'b0, (^d) ^ flip, rdy_last, ec_last);
      check_model(tag);
   endtask

   task automatic add(input logic en, input logic s, input logic b, input logic rdy, input logic ec,
                      input logic ev, input logic [W-1:0] ew, input logic ep, input logic eo);
      vec_t v;
      v.en = en; v.s = s; v.b = b; v.rdy = rdy; v.ec = ec;
      v.ev = ev; v.ew = ew; v.ep = ep; v.eo = eo;
      tbl.push_back(v);
   endtask

   task automatic add_data(input logic [W-1:0] d, input logic [W-1:0] ew, input logic ep);
      for (int i = 0; i < int'(W); i++) add(1'b1, i == 0, d[i], 1'b1, 1'b0, 1'b0, ew, ep, 1'b0);
   endtask

   initial begin
      int unsigned base;
      logic [W-1:0] rd;

      // reset state
      #1 clr_n = 1'b0;
      #2;
      chk("rst.valid", 32'(word_valid), 32'd0);
      chk("rst.word",  32'(word_out),   32'd0);
      chk("rst.perr",  32'(parity_err), 32'd0);
      chk("rst.ovr",   32'(overrun),    32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      clr_n = 1'b1;
      @(posedge clk);
      #1;

      // directed table: good 4D, bad-parity 4D, err_clr colliding with a bad frame
      add_data(8'h4D, 8'h00, 1'b0);
      add(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b0, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b0, 1'b0);
      add_data(8'h4D, 8'h4D, 1'b0);
      add(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h4D, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h4D, 1'b1, 1'b0);
      add_data(8'h4D, 8'h4D, 1'b1);
      add(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'h4D, 1'b1, 1'b0);
      add(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'h4D, 1'b0, 1'b0);
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].en, tbl[i].s, tbl[i].b, tbl[i].rdy, tbl[i].ec);
         chk($sformatf("tbl%0d.valid", i), 32'(word_valid), 32'(tbl[i].ev));
         chk($sformatf("tbl%0d.word", i),  32'(word_out),   32'(tbl[i].ew));
         chk($sformatf("tbl%0d.perr", i),  32'(parity_err), 32'(tbl[i].ep));
         chk($sformatf("tbl%0d.ovr", i),   32'(overrun),    32'(tbl[i].eo));
      end

      // overrun: buffer held full, second word dropped
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "ovA");
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "ovB");
      chk("ovr.word_kept", 32'(word_out), 32'hA5);
      chk("ovr.flag",      32'(overrun),  32'd1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      check_model("drain");
      chk("drain.valid", 32'(word_valid), 32'd0);

      // ready raised exactly on the second completion
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "rdA");
      send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, "rdB");
      chk("rdy_edge.word",  32'(word_out),   32'h3C);
      chk("rdy_edge.valid", 32'(word_valid), 32'd1);
      chk("rdy_edge.ovr",   32'(overrun),    32'd0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_model("rdy_idle");

      // abort after 4 data bits, then a full FF frame
      base = words_seen;
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      check_model("abort");
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
         check_model("abort");
      end
      send_frame(8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, "abFF");
      chk("abort.word", 32'(word_out), 32'hFF);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_model("abort_idle");
      chk("abort.count", words_seen - base, 32'd1);
      chk("abort.flags", {parity_err, overrun}, 32'd0);

      // reset mid-DATA with a pending word and a set flag
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, "prerst");
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #2 clr_n = 1'b0;
      #1;
      chk("midrst.valid", 32'(word_valid), 32'd0);
      chk("midrst.word",  32'(word_out),   32'd0);
      chk("midrst.perr",  32'(parity_err), 32'd0);
      chk("midrst.ovr",   32'(overrun),    32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      clr_n = 1'b1;
      @(posedge clk);
      #1;
      base = words_seen;
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'(i), 1'b1, 1'b0);
         check_model("nosof");
      end
      send_frame(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, "post");
      chk("post.word", 32'(word_out), 32'h01);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_model("post_idle");
      chk("post.count", words_seen - base, 32'd1);

      // random traffic against the model
      for (int i = 0; i < 800; i++) begin
         logic en;
         en = ($urandom % 4) != 0;
         cyc(en, en && (($urandom % 12) == 0), 1'($urandom), 1'($urandom), ($urandom % 16) == 0);
         check_model("rand");
      end
      for (int i = 0; i < 20; i++) begin
         rd = W'($urandom);
         send_frame(rd, 1'($urandom), 1'($urandom), 1'($urandom), ($urandom % 4) == 0, "rframe");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bit_deser.md
# bit_deser

Serial-to-parallel capture stage that sits directly downstream of a chain of s-module logic cells. It samples their registered single-bit output as a framed LSB-first stream: WIDTH data bits followed by one even-parity bit. It presents each completed word on a valid/ready interface to the next stage. Words are double-buffered, so a new frame can shift in while the previous word waits to be accepted.

## Interface
- WIDTH, 8, data bits per frame (2..32)
- clk  input  1  rising-edge clock for all state
- clr_n  input  1  reset: asynchronous and active-low
- bit_in  input  1  serial data bit from the upstream cell output
- bit_en  input  1  qualifies bit_in; a bit is consumed only on cycles with bit_en=1
- sof  input  1  start of frame; valid only with bit_en=1; marks bit_in as data bit 0
- err_clr  input  1  synchronous clear of the sticky error flags
- word_out  output  WIDTH  last completed word, bit 0 = first received bit
- word_valid  output  1  word_out holds an unaccepted word
- word_ready  input  1  downstream accepts word_out when word_valid=1
- parity_err  output  1  sticky; set when a completed frame fails even parity
- overrun  output  1  sticky; set when a frame completes while the output buffer is still full

## Operation
- FSM states: IDLE, DATA, PAR. Reset enters IDLE.
- IDLE: on sof&bit_en, load bit_in into shift bit 0, set cnt=1, go to DATA. bit_en without sof is ignored.
- DATA: each bit_en shifts bit_in into position cnt and increments cnt.
  - When the bit at position WIDTH-1 is taken, go to PAR.
  - Running parity accumulates the XOR of all data bits.
- PAR: the next bit_en supplies the parity bit. The frame is complete and the FSM returns to IDLE.
- Parity check: a frame is good when the XOR of the data bits and the parity bit is 0.
  - A bad frame sets parity_err.
  - The word is still delivered.
- Completion with output buffer free, or freed in the same cycle: load word_out and set word_valid.
- Completion with word_valid=1 and word_ready=0: drop the new word, keep word_out unchanged, set overrun.
- sof&bit_en in DATA or PAR aborts the current frame and restarts at data bit 0. No flag is raised.
- Handshake: a transfer occurs on a clk edge with word_valid&word_ready. word_valid drops the next cycle unless a new word loads in that same edge.
- err_clr clears both sticky flags. If err_clr coincides with a new error event, the flag stays set (set wins).
- Reset values:
  - FSM in IDLE, cnt=0, shift register 0.
  - word_out=0, word_valid=0, parity_err=0, overrun=0.
- Reset mid-frame discards partial data. No word is emitted.

## Timing
- word_valid and word_out update on the edge that samples the parity bit. They are visible the cycle after bit_en of the parity bit.
- Minimum frame period: WIDTH+1 bit_en cycles. Back-to-back frames with bit_en held high are supported at full rate.
- parity_err and overrun update on the same edge as the completion.
- word_ready is sampled only when word_valid=1. A combinational path from word_ready to any output is not permitted.
- cnt width: $clog2(WIDTH). cnt returns to 0 when entering PAR.

## Structure
- Shared package bit_deser_pkg holds:
  - state enum (IDLE=2'b00, DATA=2'b01, PAR=2'b10)
  - PARITY_EVEN constant
  - WIDTH range limits
- Sub-module deser_fsm holds the state register, bit counter and sof/abort logic. It outputs shift_en, bit_idx and frame_done.
- The top level holds the shift register, parity accumulator, output buffer and flags.

## Test plan
- WIDTH=8: send sof with stream 1,0,1,1,0,0,1,0 then parity 0, with word_ready=1.
  - word_out=8'h4D, word_valid for 1 cycle, parity_err=0.
- Same data with parity 1: word_out=8'h4D, parity_err=1 and stays 1 until err_clr.
  - Assert err_clr and a bad frame in the same cycle: parity_err remains 1.
- Hold word_ready=0. Send two good frames back to back (8'hA5, 8'h3C).
  - word_out stays 8'hA5, overrun=1.
  - Raise word_ready exactly on the second completion cycle: word_out=8'h3C, overrun=0.
- Abort: sof after 4 data bits, then a full frame 8'hFF with parity 0.
  - A single word 8'hFF is delivered and no flag is set.
- Drop clr_n mid-DATA, release, send frame 8'h01 with parity 1.
  - All outputs are 0 during reset. Exactly one word 8'h01 follows.
  - Idle bit_en pulses without sof produce nothing.
